// File: rtl/pipe_pkg.sv
// Shared widths, ALU opcodes and the ID/EX register layout for the pipeline.
package pipe_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MOV  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic                  use_imm;
        logic [2:0]            alu_ctrl;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  reg_write;
        logic                  mem_read;
    } id_ex_t;

    // Bubble is an all-zero register: no writeback, no load, r0 sources.
    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:     1'b0,
        rs_addr:   {REG_ADDR_W{1'b0}},
        rt_addr:   {REG_ADDR_W{1'b0}},
        rs_data:   {DATA_W{1'b0}},
        rt_data:   {DATA_W{1'b0}},
        imm:       {DATA_W{1'b0}},
        use_imm:   1'b0,
        alu_ctrl:  ALU_ADD,
        rd_addr:   {REG_ADDR_W{1'b0}},
        reg_write: 1'b0,
        mem_read:  1'b0
    };
endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, forwarding sources and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if;
    import pipe_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic                  id_use_imm;
    logic [2:0]            id_alu_ctrl;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  hold;
    logic [REG_ADDR_W-1:0] exmem_rd_addr;
    logic [REG_ADDR_W-1:0] memwb_rd_addr;
    logic                  exmem_reg_write;
    logic                  memwb_reg_write;
    logic [DATA_W-1:0]     exmem_result;
    logic [DATA_W-1:0]     memwb_data;
    logic [DATA_W-1:0]     ex_a;
    logic [DATA_W-1:0]     ex_b;
    logic [2:0]            ex_alu_ctrl;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_valid;
    logic                  stall_id;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
               id_use_imm, id_alu_ctrl, id_rd_addr, id_reg_write, id_mem_read,
               flush, hold, exmem_rd_addr, memwb_rd_addr, exmem_reg_write,
               memwb_reg_write, exmem_result, memwb_data,
        input  ex_a, ex_b, ex_alu_ctrl, ex_rd_addr, ex_reg_write, ex_mem_read,
               ex_valid, stall_id
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
               id_use_imm, id_alu_ctrl, id_rd_addr, id_reg_write, id_mem_read,
               flush, hold, exmem_rd_addr, memwb_rd_addr, exmem_reg_write,
               memwb_reg_write, exmem_result, memwb_data,
        output ex_a, ex_b, ex_alu_ctrl, ex_rd_addr, ex_reg_write, ex_mem_read,
               ex_valid, stall_id
    );
endinterface

// File: rtl/fwd_mux.sv
// EX operand forwarding select; purely combinational, no backpressure.
// EX/MEM wins over MEM/WB; r0 is never forwarded since it is hardwired zero.
module fwd_mux
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_src_addr,
    input  logic [DATA_W-1:0]     i_reg_data,
    input  logic                  i_exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_exmem_rd_addr,
    input  logic [DATA_W-1:0]     i_exmem_result,
    input  logic                  i_memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_memwb_rd_addr,
    input  logic [DATA_W-1:0]     i_memwb_data,
    output logic [DATA_W-1:0]     o_data
);
    logic w_src_nz;

    assign w_src_nz = (i_src_addr != {REG_ADDR_W{1'b0}});

    always_comb begin
        o_data = i_reg_data;
        if (w_src_nz && i_exmem_reg_write && (i_exmem_rd_addr == i_src_addr)) begin
            o_data = i_exmem_result;
        end else if (w_src_nz && i_memwb_reg_write && (i_memwb_rd_addr == i_src_addr)) begin
            o_data = i_memwb_data;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register feeding MainALU with forwarded operands; 1-cycle ID-to-EX latency.
// Backpressure: hold freezes the stage, load-use inserts one bubble; stall_id holds PC and IF/ID.
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave io_bus
);
    id_ex_t              r_st;
    id_ex_t              w_id;
    logic                w_hazard;
    logic [DATA_W-1:0]   w_rs_fwd;
    logic [DATA_W-1:0]   w_rt_fwd;

    always_comb begin
        w_id           = ID_EX_BUBBLE;
        w_id.valid     = io_bus.id_valid;
        w_id.rs_addr   = io_bus.id_rs_addr;
        w_id.rt_addr   = io_bus.id_rt_addr;
        w_id.rs_data   = io_bus.id_rs_data;
        w_id.rt_data   = io_bus.id_rt_data;
        w_id.imm       = io_bus.id_imm;
        w_id.use_imm   = io_bus.id_use_imm;
        w_id.alu_ctrl  = io_bus.id_alu_ctrl;
        w_id.rd_addr   = io_bus.id_rd_addr;
        w_id.reg_write = io_bus.id_valid & io_bus.id_reg_write;
        w_id.mem_read  = io_bus.id_valid & io_bus.id_mem_read;
    end

    // A load in EX cannot be forwarded yet; rt only matters when B is not the immediate.
    assign w_hazard = r_st.valid & r_st.mem_read & r_st.reg_write
                    & (r_st.rd_addr != {REG_ADDR_W{1'b0}})
                    & ((r_st.rd_addr == io_bus.id_rs_addr)
                       | (~io_bus.id_use_imm & (r_st.rd_addr == io_bus.id_rt_addr)))
                    & io_bus.id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= ID_EX_BUBBLE;
        end else if (io_bus.flush) begin
            r_st <= ID_EX_BUBBLE;
        end else if (!io_bus.hold) begin
            r_st <= w_hazard ? ID_EX_BUBBLE : w_id;
        end
    end

    fwd_mux u_fwd_a (
        .i_src_addr        (r_st.rs_addr),
        .i_reg_data        (r_st.rs_data),
        .i_exmem_reg_write (io_bus.exmem_reg_write),
        .i_exmem_rd_addr   (io_bus.exmem_rd_addr),
        .i_exmem_result    (io_bus.exmem_result),
        .i_memwb_reg_write (io_bus.memwb_reg_write),
        .i_memwb_rd_addr   (io_bus.memwb_rd_addr),
        .i_memwb_data      (io_bus.memwb_data),
        .o_data            (w_rs_fwd)
    );

    fwd_mux u_fwd_b (
        .i_src_addr        (r_st.rt_addr),
        .i_reg_data        (r_st.rt_data),
        .i_exmem_reg_write (io_bus.exmem_reg_write),
        .i_exmem_rd_addr   (io_bus.exmem_rd_addr),
        .i_exmem_result    (io_bus.exmem_result),
        .i_memwb_reg_write (io_bus.memwb_reg_write),
        .i_memwb_rd_addr   (io_bus.memwb_rd_addr),
        .i_memwb_data      (io_bus.memwb_data),
        .o_data            (w_rt_fwd)
    );

    assign io_bus.ex_a         = w_rs_fwd;
    assign io_bus.ex_b         = r_st.use_imm ? r_st.imm : w_rt_fwd;
    assign io_bus.ex_alu_ctrl  = r_st.alu_ctrl;
    assign io_bus.ex_rd_addr   = r_st.rd_addr;
    assign io_bus.ex_reg_write = r_st.reg_write;
    assign io_bus.ex_mem_read  = r_st.mem_read;
    assign io_bus.ex_valid     = r_st.valid;
    assign io_bus.stall_id     = io_bus.hold | (w_hazard & ~io_bus.flush);
endmodule
